// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side companion for a synchronous block-RAM FIFO with registered reads
// (1-cycle read latency). It drains the FIFO and presents the words as a
// valid/ready stream with registered outputs. A 2-entry output buffer lets it
// sustain one word per cycle while the consumer is ready. It never loses a
// word the FIFO has already released.
//
// Parameters:
//   DATA_WIDTH      width of FIFO words and of outData (default 8)
//
// Ports:
//   clock           system clock, shared with the FIFO
//   asyncReset      asynchronous, active-high reset
//   flush           synchronous discard of all buffered and in-flight words
//   fifoReadEnable  read strobe to the FIFO (combinational from outReady,
//                   fifoEmpty and flush)
//   fifoEmpty       FIFO empty flag
//   fifoReadData    FIFO read data, valid the cycle after an accepted read
//   outValid        outData holds a word (registered)
//   outReady        consumer accepts the word when outValid && outReady
//   outData         head word (registered)
//
// Optional feature, enabled by defining FIFO_STREAM_READER_STALL_COUNT_EN:
//   stallCountClear input, synchronously zeroes stallCount (wins over count)
//   stallCount      16-bit saturating count of cycles with outValid && !outReady
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  asyncReset,
  input  logic                  flush,
  output logic                  fifoReadEnable,
  input  logic                  fifoEmpty,
  input  logic [DATA_WIDTH-1:0] fifoReadData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData
`ifdef FIFO_STREAM_READER_STALL_COUNT_EN
  ,
  input  logic                  stallCountClear,
  output logic [15:0]           stallCount
`endif
);

  // Buffer state: count words held (head + second), pending = read in flight.
  logic [1:0]            count_q, count_d;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] second_q, second_d;
  logic [DATA_WIDTH-1:0] head_d;
  logic [1:0]            remain;
  logic [2:0]            occupancy;
  logic                  pop;
  logic                  fetch;

  // Fetch decision. Occupancy counts the in-flight word too, so a read is only
  // issued when a buffer slot is guaranteed to be free when its data arrives.
  // Holding fetch low during reset keeps the FIFO pointer still while the
  // buffer is being cleared.
  always_comb begin
    pop       = outValid && outReady;
    occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
    fetch     = !asyncReset && !fifoEmpty && !flush && (occupancy < 3'd2);
  end

  assign fifoReadEnable = fetch;

  // Next buffer contents. The arriving word goes to the head when the buffer is
  // empty after this cycle's pop, otherwise behind the head; a pop with two
  // words held shifts the second word forward in the same edge.
  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    head_d   = outData;
    second_d = second_q;
    remain   = count_q - {1'b0, pop};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && (count_q == 2'd2)) begin
        head_d = second_q;
      end
      if (pending_q) begin
        if (remain == 2'd0) begin
          head_d = fifoReadData;
        end else begin
          second_d = fifoReadData;
        end
        count_d = remain + 2'd1;
      end else begin
        count_d = remain;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or posedge asyncReset) begin
    if (asyncReset) begin
      count_q   <= 2'd0;
      pending_q <= 1'b0;
      outValid  <= 1'b0;
      outData   <= '0;
      second_q  <= '0;
    end else begin
      count_q   <= count_d;
      // fetch is already low during flush, so the in-flight word is dropped.
      pending_q <= fetch;
      outValid  <= (count_d != 2'd0);
      outData   <= head_d;
      second_q  <= second_d;
    end
  end

`ifdef FIFO_STREAM_READER_STALL_COUNT_EN
  always_ff @(posedge clock or posedge asyncReset) begin
    if (asyncReset) begin
      stallCount <= 16'd0;
    end else if (stallCountClear) begin
      stallCount <= 16'd0;
    end else if (outValid && !outReady && (stallCount != 16'hFFFF)) begin
      stallCount <= stallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. A behavioural FIFO with a
// registered read port feeds the DUT. Each word the consumer should receive is
// pushed into exp_q when it is loaded, and a negedge monitor pops and compares
// on every outValid && outReady handshake.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  logic       clock = 1'b0;
  logic       asyncReset = 1'b1;
  logic       flush = 1'b0;
  logic       fifoReadEnable;
  logic       fifoEmpty = 1'b1;
  logic [7:0] fifoReadData = 8'h00;
  logic       outValid;
  logic       outReady = 1'b0;
  logic [7:0] outData;
`ifdef FIFO_STREAM_READER_STALL_COUNT_EN
  logic        stallCountClear = 1'b0;
  logic [15:0] stallCount;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int rd_violations = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  fifo_stream_reader #(.DATA_WIDTH(8)) dut (
    .clock          (clock),
    .asyncReset     (asyncReset),
    .flush          (flush),
    .fifoReadEnable (fifoReadEnable),
    .fifoEmpty      (fifoEmpty),
    .fifoReadData   (fifoReadData),
    .outValid       (outValid),
    .outReady       (outReady),
    .outData        (outData)
`ifdef FIFO_STREAM_READER_STALL_COUNT_EN
    ,
    .stallCountClear(stallCountClear),
    .stallCount     (stallCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: registered read data, empty flag updated with the read.
  always @(posedge clock) begin
    if (fifoReadEnable && fifo_q.size() > 0) begin
      fifoReadData <= fifo_q.pop_front();
      fifoEmpty    <= (fifo_q.size() == 0);
    end
  end

  // Monitor: compare every delivered word against the scoreboard.
  always @(negedge clock) begin
    if (!asyncReset) begin
      if (fifoReadEnable && fifoEmpty) rd_violations++;
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected word", {24'h0, outData}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("stream data", {24'h0, outData}, {24'h0, e});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] w, input bit expect_it);
    fifo_q.push_back(w);
    fifoEmpty = 1'b0;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic do_reset();
    asyncReset = 1'b1;
    flush      = 1'b0;
    outReady   = 1'b0;
`ifdef FIFO_STREAM_READER_STALL_COUNT_EN
    stallCountClear = 1'b0;
`endif
    fifo_q.delete();
    exp_q.delete();
    fifoEmpty = 1'b1;
    step();
    step();
    check("reset outValid", {31'h0, outValid}, 32'h0);
    check("reset outData", {24'h0, outData}, 32'h0);
    check("reset fifoReadEnable", {31'h0, fifoReadEnable}, 32'h0);
`ifdef FIFO_STREAM_READER_STALL_COUNT_EN
    check("reset stallCount", {16'h0, stallCount}, 32'h0);
`endif
    asyncReset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      step();
      cyc++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [6:0] rd_trace;
    logic [6:0] ov_trace;
    int reads;

    // 1: preloaded FIFO, consumer always ready.
    do_reset();
    load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
    outReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      rd_trace[i] = fifoReadEnable;
      ov_trace[i] = outValid;
    end
    check("t1 read strobe trace", {25'h0, rd_trace}, 32'h07);
    check("t1 outValid trace", {25'h0, ov_trace}, 32'h1C);
    check("t1 all delivered", exp_q.size(), 0);

    // 2: backpressure fill, then release.
    do_reset();
    for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i), 1);
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      reads += int'(fifoReadEnable);
    end
    check("t2 reads under backpressure", reads, 2);
    check("t2 outValid held", {31'h0, outValid}, 32'h1);
    check("t2 outData held", {24'h0, outData}, 32'hA0);
    step();
    outReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      ov_trace[i] = outValid;
    end
    check("t2 gapless outValid", {25'h0, ov_trace}, 32'h1F);
    check("t2 all delivered", exp_q.size(), 0);

    // 3: 64 words with random consumer readiness.
    do_reset();
    rd_violations = 0;
    for (int i = 0; i < 64; i++) load(8'(i), 1);
    begin
      int cyc = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        outReady = 1'($urandom_range(0, 1));
        step();
        cyc++;
      end
    end
    check("t3 random stream drained", exp_q.size(), 0);
    check("t3 read while empty", rd_violations, 0);

    // 4: flush with one word buffered and one in flight.
    do_reset();
    load(8'hB0, 0);
    step();
    step();
    load(8'hB1, 0); load(8'hB2, 0);
    step();
    flush = 1'b1;
    @(negedge clock);
    check("t4 fetch blocked by flush", {31'h0, fifoReadEnable}, 32'h0);
    check("t4 outValid before flush edge", {31'h0, outValid}, 32'h1);
    step();
    flush = 1'b0;
    exp_q.push_back(8'hB2);
    outReady = 1'b1;
    @(negedge clock);
    check("t4 outValid after flush", {31'h0, outValid}, 32'h0);
    drain("t4 first word after flush", 20);

    // 5: asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 6; i++) load(8'hC0 + 8'(i), 1);
    outReady = 1'b1;
    step(); step(); step();
    check("t5 streaming outValid", {31'h0, outValid}, 32'h1);
    check("t5 streaming read strobe", {31'h0, fifoReadEnable}, 32'h1);
    #1;
    asyncReset = 1'b1;
    #1;
    check("t5 async outValid", {31'h0, outValid}, 32'h0);
    check("t5 async fifoReadEnable", {31'h0, fifoReadEnable}, 32'h0);
    check("t5 async outData", {24'h0, outData}, 32'h0);
    fifo_q.delete();
    exp_q.delete();
    fifoEmpty = 1'b1;
    step();
    asyncReset = 1'b0;
    load(8'hE0, 1);
    drain("t5 recovery word", 20);

`ifdef FIFO_STREAM_READER_STALL_COUNT_EN
    // 6: stall counter.
    do_reset();
    load(8'hD0, 1);
    step(); step();
    check("t6 word waiting", {31'h0, outValid}, 32'h1);
    stallCountClear = 1'b1;
    step();
    stallCountClear = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t6 five stalls", {16'h0, stallCount}, 32'h5);
    stallCountClear = 1'b1;
    step();
    stallCountClear = 1'b0;
    check("t6 clear beats stall", {16'h0, stallCount}, 32'h0);
    for (int i = 0; i < 70000; i++) step();
    check("t6 saturation", {16'h0, stallCount}, 32'hFFFF);
    outReady = 1'b1;
    drain("t6 held word", 20);
`endif

    check("final read while empty", rd_violations, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
